vend_slot_table: RTL and testbench

- Parametrised, programmable successor to the fixed code-to-price decoder.
- Holds a per-slot price and stock count, loadable at run time.
- Answers registered lookups, executes vend (stock decrement) commands and supports a sequenced clear-all.
- Sits between the keypad code-entry logic and the payment/dispense controller.

---
 rtl/vend_slot_table.sv | 209 ++++++++++++++++++++
 tb/tb_vend_slot_table.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_slot_table.sv
// Programmable slot table: per-slot enable, price and stock with registered lookup,
// vend (stock decrement), run-time configuration writes and a sequenced clear-all.
module vend_slot_table #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 3,
  parameter int PRICE_W  = 13,
  parameter int STOCK_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lookup_req,
  input  logic [15:0]        lookup_code,
  output logic               rsp_valid,
  output logic               rsp_code_v,
  output logic [PRICE_W-1:0] rsp_price,
  output logic [STOCK_W-1:0] rsp_stock,
  output logic               rsp_sold_out,
  input  logic               vend_req,
  input  logic [15:0]        vend_code,
  output logic               vend_ok,
  output logic               vend_err,
  input  logic               cfg_we,
  input  logic [15:0]        cfg_code,
  input  logic [PRICE_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  output logic               cfg_err,
  input  logic               clear_all,
  output logic               busy
);

  localparam int DEPTH = NUM_ROWS * NUM_COLS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Rows start at letter A (0xA); columns are numbered from 1.
  function automatic logic code_legal(input logic [15:0] c);
    int row;
    int col;
    row = int'(c[7:4]) - 10;
    col = int'(c[3:0]);
    return (c[15:8] == 8'h00) && (row >= 0) && (row < NUM_ROWS) &&
           (col >= 1) && (col <= NUM_COLS);
  endfunction

  function automatic logic [IDX_W-1:0] slot_idx(input logic [7:0] c);
    int tmp;
    tmp = (int'(c[7:4]) - 10) * NUM_COLS + int'(c[3:0]) - 1;
    return IDX_W'(tmp);
  endfunction

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [DEPTH-1:0]                  en_q, en_d;
  logic [DEPTH-1:0][PRICE_W-1:0]     price_q, price_d;
  logic [DEPTH-1:0][STOCK_W-1:0]     stock_q, stock_d;
  logic                              busy_q, busy_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic                              rsp_code_v_q, rsp_code_v_d;
  logic [PRICE_W-1:0]                rsp_price_q, rsp_price_d;
  logic [STOCK_W-1:0]                rsp_stock_q, rsp_stock_d;
  logic                              rsp_sold_out_q, rsp_sold_out_d;
  logic                              vend_ok_q, vend_ok_d;
  logic                              vend_err_q, vend_err_d;
  logic                              cfg_err_q, cfg_err_d;

  logic                              lk_legal_s, vd_legal_s, cf_legal_s;
  logic [IDX_W-1:0]                  lk_idx_s, vd_idx_s, cf_idx_s;

  assign lk_legal_s = code_legal(lookup_code);
  assign vd_legal_s = code_legal(vend_code);
  assign cf_legal_s = code_legal(cfg_code);
  assign lk_idx_s   = slot_idx(lookup_code[7:0]);
  assign vd_idx_s   = slot_idx(vend_code[7:0]);
  assign cf_idx_s   = slot_idx(cfg_code[7:0]);

  // Next-state: lookup response, then at most one table-modifying command per edge.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    en_d           = en_q;
    price_d        = price_q;
    stock_d        = stock_q;
    busy_d         = busy_q;
    rsp_valid_d    = lookup_req;
    rsp_code_v_d   = rsp_code_v_q;
    rsp_price_d    = rsp_price_q;
    rsp_stock_d    = rsp_stock_q;
    rsp_sold_out_d = rsp_sold_out_q;
    vend_ok_d      = 1'b0;
    vend_err_d     = 1'b0;
    cfg_err_d      = 1'b0;

    // Lookups see the table as it stands before this edge's command.
    if (lookup_req) begin
      if (lk_legal_s && (state_q == ST_IDLE) && en_q[lk_idx_s]) begin
        rsp_code_v_d   = 1'b1;
        rsp_price_d    = price_q[lk_idx_s];
        rsp_stock_d    = stock_q[lk_idx_s];
        rsp_sold_out_d = (stock_q[lk_idx_s] == '0);
      end else begin
        rsp_code_v_d   = 1'b0;
        rsp_price_d    = '0;
        rsp_stock_d    = '0;
        rsp_sold_out_d = 1'b0;
      end
    end else begin
      rsp_code_v_d = rsp_code_v_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (clear_all) begin
          state_d    = ST_CLEAR;
          idx_d      = '0;
          busy_d     = 1'b1;
          cfg_err_d  = cfg_we;
          vend_err_d = vend_req;
        end else if (cfg_we) begin
          vend_err_d = vend_req;
          if (cf_legal_s) begin
            en_d[cf_idx_s]    = 1'b1;
            price_d[cf_idx_s] = cfg_price;
            stock_d[cf_idx_s] = cfg_stock;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (vend_req) begin
          if (vd_legal_s && en_q[vd_idx_s] && (stock_q[vd_idx_s] != '0)) begin
            stock_d[vd_idx_s] = stock_q[vd_idx_s] - STOCK_W'(1);
            vend_ok_d         = 1'b1;
          end else begin
            vend_err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        en_d[idx_q]    = 1'b0;
        price_d[idx_q] = '0;
        stock_d[idx_q] = '0;
        cfg_err_d      = cfg_we;
        vend_err_d     = vend_req;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, table and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      en_q           <= '0;
      price_q        <= '0;
      stock_q        <= '0;
      busy_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_code_v_q   <= 1'b0;
      rsp_price_q    <= '0;
      rsp_stock_q    <= '0;
      rsp_sold_out_q <= 1'b0;
      vend_ok_q      <= 1'b0;
      vend_err_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      en_q           <= en_d;
      price_q        <= price_d;
      stock_q        <= stock_d;
      busy_q         <= busy_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_code_v_q   <= rsp_code_v_d;
      rsp_price_q    <= rsp_price_d;
      rsp_stock_q    <= rsp_stock_d;
      rsp_sold_out_q <= rsp_sold_out_d;
      vend_ok_q      <= vend_ok_d;
      vend_err_q     <= vend_err_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_code_v   = rsp_code_v_q;
  assign rsp_price    = rsp_price_q;
  assign rsp_stock    = rsp_stock_q;
  assign rsp_sold_out = rsp_sold_out_q;
  assign vend_ok      = vend_ok_q;
  assign vend_err     = vend_err_q;
  assign cfg_err      = cfg_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_slot_table.sv
// Directed bench for vend_slot_table (3x3 default) with hand-computed expectations.
module tb_vend_slot_table;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_req;
  logic [15:0] lookup_code;
  logic        rsp_valid, rsp_code_v, rsp_sold_out;
  logic [12:0] rsp_price;
  logic [3:0]  rsp_stock;
  logic        vend_req;
  logic [15:0] vend_code;
  logic        vend_ok, vend_err;
  logic        cfg_we;
  logic [15:0] cfg_code;
  logic [12:0] cfg_price;
  logic [3:0]  cfg_stock;
  logic        cfg_err;
  logic        clear_all;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int busy_cnt;

  vend_slot_table dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_req(lookup_req), .lookup_code(lookup_code),
    .rsp_valid(rsp_valid), .rsp_code_v(rsp_code_v), .rsp_price(rsp_price),
    .rsp_stock(rsp_stock), .rsp_sold_out(rsp_sold_out),
    .vend_req(vend_req), .vend_code(vend_code), .vend_ok(vend_ok), .vend_err(vend_err),
    .cfg_we(cfg_we), .cfg_code(cfg_code), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
    .cfg_err(cfg_err), .clear_all(clear_all), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lookup_req = 1'b0; vend_req = 1'b0; cfg_we = 1'b0; clear_all = 1'b0;
  endtask

  task automatic do_lookup(input logic [15:0] c);
    lookup_code = c; lookup_req = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_write(input logic [15:0] c, input logic [12:0] p, input logic [3:0] s);
    cfg_code = c; cfg_price = p; cfg_stock = s; cfg_we = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_vend(input logic [15:0] c);
    vend_code = c; vend_req = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_code = 16'h0000; vend_code = 16'h0000; cfg_code = 16'h0000;
    cfg_price = 13'd0; cfg_stock = 4'd0;
    idle_inputs();
    #23;
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_vend_ok", vend_ok, 1'b0);
    chk("reset_cfg_err", cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Empty table lookup, one-cycle response pulse
    do_lookup(16'h00A1);
    chk("a1_valid", rsp_valid, 1'b1);
    chk("a1_code_v", rsp_code_v, 1'b0);
    chk("a1_price", rsp_price, 13'd0);
    chk("a1_stock", rsp_stock, 4'd0);
    tick();
    chk("a1_valid_drop", rsp_valid, 1'b0);

    // Write B3 and look it up
    do_write(16'h00B3, 13'd125, 4'd2);
    chk("b3_wr_cfg_err", cfg_err, 1'b0);
    do_lookup(16'h00B3);
    chk("b3_code_v", rsp_code_v, 1'b1);
    chk("b3_price", rsp_price, 13'd125);
    chk("b3_stock", rsp_stock, 4'd2);
    chk("b3_sold", rsp_sold_out, 1'b0);
    tick();
    chk("b3_hold_price", rsp_price, 13'd125);

    // Illegal codes: column out of range, row out of range, nonzero high byte
    do_write(16'h00A1, 13'd50, 4'd1);
    do_lookup(16'h00A4);
    chk("ill_a4", rsp_code_v, 1'b0);
    do_lookup(16'h00D1);
    chk("ill_d1", rsp_code_v, 1'b0);
    do_lookup(16'h01A1);
    chk("ill_01a1", rsp_code_v, 1'b0);
    do_lookup(16'h00A1);
    chk("a1_legal", rsp_code_v, 1'b1);
    chk("a1_legal_price", rsp_price, 13'd50);
    do_write(16'h00A0, 13'd7, 4'd7);
    chk("ill_write_cfg_err", cfg_err, 1'b1);
    tick();
    chk("cfg_err_pulse", cfg_err, 1'b0);
    do_vend(16'h00C1);
    chk("vend_disabled_err", vend_err, 1'b1);

    // Vend B3 down to zero, no wrap
    do_vend(16'h00B3);
    chk("vend1_ok", vend_ok, 1'b1);
    chk("vend1_err", vend_err, 1'b0);
    do_vend(16'h00B3);
    chk("vend2_ok", vend_ok, 1'b1);
    do_vend(16'h00B3);
    chk("vend3_ok", vend_ok, 1'b0);
    chk("vend3_err", vend_err, 1'b1);
    do_lookup(16'h00B3);
    chk("b3_empty_stock", rsp_stock, 4'd0);
    chk("b3_sold_out", rsp_sold_out, 1'b1);

    // Same-cycle write, vend and lookup
    do_write(16'h00B3, 13'd125, 4'd1);
    cfg_code = 16'h00A2; cfg_price = 13'd100; cfg_stock = 4'd5; cfg_we = 1'b1;
    vend_code = 16'h00B3; vend_req = 1'b1;
    lookup_code = 16'h00A2; lookup_req = 1'b1;
    tick();
    idle_inputs();
    chk("same_vend_err", vend_err, 1'b1);
    chk("same_vend_ok", vend_ok, 1'b0);
    chk("same_cfg_err", cfg_err, 1'b0);
    chk("same_lookup_prewrite", rsp_code_v, 1'b0);
    do_lookup(16'h00B3);
    chk("same_b3_stock", rsp_stock, 4'd1);
    do_lookup(16'h00A2);
    chk("same_a2_code_v", rsp_code_v, 1'b1);
    chk("same_a2_price", rsp_price, 13'd100);
    chk("same_a2_stock", rsp_stock, 4'd5);

    // Load all slots: slot i gets price 10*i+1, stock i+1
    for (int i = 0; i < 9; i++) begin
      do_write({8'h00, 4'(10 + i / 3), 4'(i % 3 + 1)}, 13'(10 * i + 1), 4'(i + 1));
    end
    do_lookup(16'h00C3);
    chk("c3_price", rsp_price, 13'd81);
    chk("c3_stock", rsp_stock, 4'd9);

    // Clear sequence with a concurrent write
    clear_all = 1'b1;
    cfg_code = 16'h00A1; cfg_price = 13'd9; cfg_stock = 4'd9; cfg_we = 1'b1;
    tick();
    idle_inputs();
    chk("clr_start_busy", busy, 1'b1);
    chk("clr_start_cfg_err", cfg_err, 1'b1);
    busy_cnt = 1;
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin
        clear_all = 1'b1;
        cfg_code = 16'h00C3; cfg_we = 1'b1;
        lookup_code = 16'h00C3; lookup_req = 1'b1;
      end
      tick();
      if (k == 2) begin
        chk("busy_cfg_err", cfg_err, 1'b1);
        chk("busy_lookup_code_v", rsp_code_v, 1'b0);
        chk("busy_lookup_valid", rsp_valid, 1'b1);
      end
      idle_inputs();
      if (busy) busy_cnt++;
      else break;
    end
    chk("busy_cycles", busy_cnt, 9);
    for (int i = 0; i < 9; i++) begin
      do_lookup({8'h00, 4'(10 + i / 3), 4'(i % 3 + 1)});
      chk("post_clear_code_v", rsp_code_v, 1'b0);
    end

    // Reset during CLEAR at index 4
    do_write(16'h00C3, 13'd33, 4'd3);
    clear_all = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_abort_busy", busy, 1'b0);
    do_lookup(16'h00C3);
    chk("post_abort_c3_cleared", rsp_code_v, 1'b0);
    do_write(16'h00C2, 13'd250, 4'd3);
    chk("post_abort_cfg_err", cfg_err, 1'b0);
    do_lookup(16'h00C2);
    chk("post_abort_c2_code_v", rsp_code_v, 1'b1);
    chk("post_abort_c2_price", rsp_price, 13'd250);
    chk("post_abort_c2_stock", rsp_stock, 4'd3);
    do_vend(16'h00C2);
    chk("post_abort_vend_ok", vend_ok, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
